// File: rtl/pwm_frame_ctrl_pkg.sv
// Shared definitions for the SPI-fed PWM frame controller: FSM encoding,
// mode byte bit positions and legal parameter ranges.
package pwm_frame_ctrl_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_MODE = 2'd1;
    localparam logic [ST_W-1:0] ST_DUTY = 2'd2;
    localparam logic [ST_W-1:0] ST_OVF  = 2'd3;

    localparam int MODE_INV = 0;
    localparam int MODE_OFF = 1;

    localparam int N_CH_MIN  = 1;
    localparam int N_CH_MAX  = 8;
    localparam int PWM_W_MIN = 4;
    localparam int PWM_W_MAX = 8;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared period counter with this channel's active duty.
// One clk latency (registered output); no flow control, always accepts.
module pwm_channel
    import pwm_frame_ctrl_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PWM_W-1:0]  cnt,
    input  logic [PWM_W-1:0]  duty,
    input  logic [MODE_OFF:0] mode_ctl,
    output logic              pwm
);

    logic raw;
    logic level;

    // Force-off is applied after inversion so an inverted channel still goes low.
    always_comb begin
        raw   = cnt < duty;
        level = mode_ctl[MODE_INV] ? !raw : raw;
        if (mode_ctl[MODE_OFF]) begin
            level = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= level;
        end
    end

endmodule

// File: rtl/pwm_frame_ctrl.sv
// Decodes SPI frames (mode + N_CH duties) into a shadow set committed at period wrap.
// PWM outputs lag the counter by 1 clk; rx bytes are never stalled, excess bytes flag frame_err.
module pwm_frame_ctrl
    import pwm_frame_ctrl_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               frame_start,
    input  logic [PRESC_W-1:0] presc_div,
    output logic [N_CH-1:0]    pwm_out,
    output logic [7:0]         mode,
    output logic [3:0]         byte_cnt,
    output logic               frame_done,
    output logic               frame_err
);

    localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'((1 << PWM_W) - 2);

    logic [ST_W-1:0]    state;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PWM_W-1:0]   cnt;
    logic               tick;
    logic               wrap;
    logic               accept;
    logic               mode_wr;
    logic               duty_wr;
    logic               frame_cmp;
    logic               pending;
    logic [PWM_W-1:0]   rx_duty;
    logic [7:0]         stg_mode;
    logic [7:0]         shd_mode;
    logic [PWM_W-1:0]   stg_duty [N_CH];
    logic [PWM_W-1:0]   shd_duty [N_CH];
    logic [PWM_W-1:0]   act_duty [N_CH];

    assign tick      = presc_cnt == presc_div;
    assign wrap      = tick && (cnt == CNT_MAX);
    assign accept    = rx_valid && !frame_start && (state != ST_IDLE);
    assign mode_wr   = accept && (state == ST_MODE);
    assign duty_wr   = accept && (state == ST_DUTY);
    assign frame_cmp = duty_wr && (byte_cnt == 4'(N_CH));
    assign rx_duty   = rx_data[7 -: PWM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (frame_start) begin
            state <= ST_MODE;
        end else if (mode_wr) begin
            state <= ST_DUTY;
        end else if (frame_cmp) begin
            state <= ST_OVF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= frame_cmp;
            if (frame_start) begin
                byte_cnt  <= '0;
                frame_err <= 1'b0;
            end else begin
                if (accept && (byte_cnt != 4'hF)) begin
                    byte_cnt <= byte_cnt + 4'd1;
                end
                if (accept && (state == ST_OVF)) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // A shrunken presc_div leaves presc_cnt above it; the counter then rolls over naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            cnt       <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            if (tick) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + PWM_W'(1);
            end
        end
    end

    // Staging holds the frame in flight so an aborted frame never disturbs a pending shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_mode <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stg_duty[i] <= '0;
            end
        end else begin
            if (mode_wr) begin
                stg_mode <= rx_data;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (duty_wr && (byte_cnt == 4'(i + 1))) begin
                    stg_duty[i] <= rx_duty;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_mode <= '0;
            pending  <= 1'b0;
            mode     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shd_duty[i] <= '0;
                act_duty[i] <= '0;
            end
        end else begin
            if (wrap && pending) begin
                mode <= shd_mode;
                for (int i = 0; i < N_CH; i++) begin
                    act_duty[i] <= shd_duty[i];
                end
            end
            // Completion on a wrap cycle keeps pending set, deferring the commit one period.
            if (frame_cmp) begin
                pending  <= 1'b1;
                shd_mode <= stg_mode;
                for (int i = 0; i < N_CH; i++) begin
                    shd_duty[i] <= (i == N_CH - 1) ? rx_duty : stg_duty[i];
                end
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt),
            .duty     (act_duty[g]),
            .mode_ctl (mode[MODE_OFF:0]),
            .pwm      (pwm_out[g])
        );
    end

endmodule
